// File: rtl/imem_boot_loader_pkg.sv
// Shared types and defaults for the instruction memory boot loader.
// State encoding, address defaults and the byte address helper.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_VERIFY_RD  = 3'd2,
    S_VERIFY_CHK = 3'd3,
    S_DONE       = 3'd4,
    S_ERROR      = 3'd5
  } boot_state_t;

  localparam int unsigned BOOT_STRIDE = 4;
  localparam int unsigned BOOT_BASE   = 0;

  // Byte address of word idx; callers truncate to their port width.
  function automatic logic [31:0] byte_addr(
    input logic [31:0] base,
    input logic [31:0] stride,
    input logic [31:0] idx
  );
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/boot_checksum.sv
// Wrapping word accumulator used for the load and readback checksums.
// Clear wins over enable so a restart never mixes in a stale word.
module boot_checksum #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);

  // Accumulate with wrap; async active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program image into instruction memory, optionally verifies
// it by checksum readback, then releases the core via resetpc.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 128,
  parameter int STRIDE = BOOT_STRIDE,
  parameter int BASE   = BOOT_BASE,
  parameter int VERIFY = 1,
  localparam int NW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NW-1:0]     num_words,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we0,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [DATA_W-1:0] wr_din0,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              resetpc,
  output logic              done,
  output logic              error
);

  boot_state_t state, state_nx;

  logic [NW-1:0]     cnt;
  logic [NW-1:0]     idx;
  logic [NW-1:0]     rdk;
  logic              rd_v1;
  logic              rd_v2;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] vsum;

  logic can_start;
  logic load_go;
  logic hs;
  logic last;
  logic issue;
  logic rd_end;
  logic vacc;

  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] ra;

  assign in_ready  = (state == S_LOAD);
  assign hs        = in_ready && in_valid;
  assign last      = (idx == cnt - NW'(1));

  assign can_start = start && (state == S_IDLE ||
                               state == S_DONE ||
                               state == S_ERROR);
  assign load_go   = can_start && (num_words != '0) &&
                     (num_words <= NW'(DEPTH));

  // Readback issues one address per cycle; data returns two edges later
  // (registered address, then synchronous memory read).
  assign issue  = (state == S_VERIFY_RD) && (rdk != cnt);
  assign rd_end = (state == S_VERIFY_RD) && (rdk == cnt) &&
                  rd_v2 && !rd_v1;
  assign vacc   = (state == S_VERIFY_RD) && rd_v2;

  assign wa = ADDR_W'(byte_addr(32'(BASE), 32'(STRIDE), 32'(idx)));
  assign ra = ADDR_W'(byte_addr(32'(BASE), 32'(STRIDE), 32'(rdk)));

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          if (num_words == '0) begin
            state_nx = S_DONE;
          end else if (num_words > NW'(DEPTH)) begin
            state_nx = S_ERROR;
          end else begin
            state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (hs && last) begin
          state_nx = (VERIFY != 0) ? S_VERIFY_RD : S_DONE;
        end
      end
      S_VERIFY_RD: begin
        if (rd_end) begin
          state_nx = S_VERIFY_CHK;
        end
      end
      S_VERIFY_CHK: begin
        state_nx = (vsum == sum) ? S_DONE : S_ERROR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and status flags; flags follow the next state so a restart
  // from DONE drops resetpc in the same edge that enters LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      resetpc <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state   <= state_nx;
      resetpc <= (state_nx == S_DONE);
      done    <= (state_nx == S_DONE);
      error   <= (state_nx == S_ERROR);
    end
  end

  // Word count capture and load/readback indices.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
      rdk <= '0;
    end else if (load_go) begin
      cnt <= num_words;
      idx <= '0;
      rdk <= '0;
    end else begin
      if (hs) begin
        idx <= idx + NW'(1);
      end
      if (issue) begin
        rdk <= rdk + NW'(1);
      end
    end
  end

  // Registered write port: one we0 pulse per accepted word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we0      <= 1'b0;
      wr_addr0 <= '0;
      wr_din0  <= '0;
    end else begin
      we0 <= hs;
      if (hs) begin
        wr_addr0 <= wa;
        wr_din0  <= in_data;
      end
    end
  end

  // Readback address and data-valid pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr <= '0;
      rd_v1   <= 1'b0;
      rd_v2   <= 1'b0;
    end else begin
      if (issue) begin
        rd_addr <= ra;
      end
      rd_v1 <= issue;
      rd_v2 <= rd_v1;
    end
  end

  boot_checksum #(.W(DATA_W)) u_load_sum (
    .clk   (clk),
    .reset (reset),
    .clr   (load_go),
    .en    (hs),
    .din   (in_data),
    .sum   (sum)
  );

  boot_checksum #(.W(DATA_W)) u_verify_sum (
    .clk   (clk),
    .reset (reset),
    .clr   (load_go),
    .en    (vacc),
    .din   (rd_data),
    .sum   (vsum)
  );

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a synchronous-read memory
// model, write/handshake monitors and per-scenario checking tasks.
module tb_imem_boot_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  num_words;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        we0;
  logic [8:0]  wr_addr0;
  logic [31:0] wr_din0;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data;
  logic        resetpc;
  logic        done;
  logic        error;

  int checks;
  int errors;
  int cyc;

  logic [31:0] mem [128];
  logic [31:0] img [128];
  logic        flip_en;
  logic        rpc_after_start;

  logic [8:0]  wlog_addr [$];
  logic [31:0] wlog_data [$];
  int          wlog_cyc  [$];
  logic        wlog_rpc  [$];
  int          hs_cyc    [$];

  imem_boot_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_words (num_words),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .we0       (we0),
    .wr_addr0  (wr_addr0),
    .wr_din0   (wr_din0),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .resetpc   (resetpc),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: write port plus one-cycle read.
  always @(posedge clk) begin
    if (we0) mem[wr_addr0[8:2]] <= wr_din0;
    rd_data <= mem[rd_addr[8:2]] ^
               ((flip_en && rd_addr == 9'd4) ? 32'h0000_0100 : 32'h0);
  end

  // Monitors for writes and stream handshakes.
  always @(posedge clk) begin
    if (we0) begin
      wlog_addr.push_back(wr_addr0);
      wlog_data.push_back(wr_din0);
      wlog_cyc.push_back(cyc);
      wlog_rpc.push_back(resetpc);
    end
    if (in_valid && in_ready) hs_cyc.push_back(cyc);
    cyc <= cyc + 1;
  end

  task automatic clear_logs();
    wlog_addr.delete();
    wlog_data.delete();
    wlog_cyc.delete();
    wlog_rpc.delete();
    hs_cyc.delete();
  endtask

  task automatic run_load(input int n, input bit toggle, input int abort_after);
    int i;
    int t;
    bit hs;
    @(negedge clk);
    start = 1'b1;
    num_words = n[7:0];
    @(negedge clk);
    rpc_after_start = resetpc;
    start = 1'b0;
    i = 0;
    t = 0;
    while (i < n && t < 2000) begin
      in_valid = toggle ? ((t % 2) == 0) : 1'b1;
      in_data = img[i];
      hs = in_valid && in_ready;
      @(negedge clk);
      t++;
      if (hs) i++;
      if (abort_after > 0 && wlog_addr.size() >= abort_after) break;
    end
    in_valid = 1'b0;
    if (abort_after == 0) begin
      checks++;
      if (i != n) begin
        errors++;
        $display("FAIL stream_timeout accepted=%0d required=%0d", i, n);
      end
    end
  endtask

  task automatic wait_end(input int limit, output int when);
    int c;
    c = 0;
    while (!(done || error) && c < limit) begin
      @(negedge clk);
      c++;
    end
    when = cyc;
    checks++;
    if (!(done || error)) begin
      errors++;
      $display("FAIL end_timeout no done/error within %0d cycles", limit);
    end
  endtask

  task automatic check_image(input string name, input int n);
    int bad;
    checks++;
    if (wlog_addr.size() != n) begin
      errors++;
      $display("FAIL %s_count got=%0d exp=%0d", name, wlog_addr.size(), n);
    end else begin
      bad = 0;
      for (int i = 0; i < n; i++) begin
        if (wlog_addr[i] !== 9'(i * 4) || wlog_data[i] !== img[i]) begin
          if (bad == 0)
            $display("FAIL %s_write[%0d] addr=%0d data=%h exp addr=%0d data=%h",
                     name, i, wlog_addr[i], wlog_data[i], i * 4, img[i]);
          bad++;
        end
      end
      if (bad != 0) errors++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++;
    if ({in_ready, we0, resetpc, done, error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000",
               {in_ready, we0, resetpc, done, error});
    end
    checks++;
    if (wr_addr0 !== 9'd0 || wr_din0 !== 32'd0 || rd_addr !== 9'd0) begin
      errors++;
      $display("FAIL reset_ports wr_addr0=%0d wr_din0=%h rd_addr=%0d exp 0",
               wr_addr0, wr_din0, rd_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int when;
    img[0] = 32'h0050_0093;
    img[1] = 32'h00A0_0113;
    img[2] = 32'h0020_81B3;
    clear_logs();
    run_load(3, 1'b0, 0);
    wait_end(40, when);
    check_image("basic", 3);
    checks++;
    if (wlog_cyc.size() == 3 &&
        (wlog_cyc[1] != wlog_cyc[0] + 1 || wlog_cyc[2] != wlog_cyc[0] + 2)) begin
      errors++;
      $display("FAIL basic_consecutive cycles=%0d,%0d,%0d", wlog_cyc[0],
               wlog_cyc[1], wlog_cyc[2]);
    end
    checks++;
    if (done !== 1'b1 || resetpc !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL basic_done done=%b resetpc=%b error=%b exp 1 1 0",
               done, resetpc, error);
    end
    checks++;
    if (wlog_cyc.size() != 3 || when - wlog_cyc[2] > 8) begin
      errors++;
      $display("FAIL basic_latency done at %0d last write %0d limit 8", when,
               (wlog_cyc.size() > 0) ? wlog_cyc[wlog_cyc.size() - 1] : -1);
    end
  endtask

  task automatic test_toggle_valid();
    int when;
    int bad;
    clear_logs();
    run_load(3, 1'b1, 0);
    wait_end(40, when);
    check_image("toggle", 3);
    checks++;
    bad = 0;
    if (hs_cyc.size() != 3 || wlog_cyc.size() != 3) begin
      bad = 1;
    end else begin
      for (int i = 0; i < 3; i++)
        if (wlog_cyc[i] != hs_cyc[i] + 1) bad = 1;
    end
    if (bad != 0) begin
      errors++;
      $display("FAIL toggle_timing hs=%0d writes=%0d (we0 must follow handshake by 1)",
               hs_cyc.size(), wlog_cyc.size());
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL toggle_done done=%b error=%b exp 1 0", done, error);
    end
  endtask

  task automatic test_verify_error();
    int when;
    clear_logs();
    flip_en = 1'b1;
    run_load(3, 1'b0, 0);
    wait_end(40, when);
    flip_en = 1'b0;
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || resetpc !== 1'b0) begin
      errors++;
      $display("FAIL verify_error error=%b done=%b resetpc=%b exp 1 0 0",
               error, done, resetpc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b1 || resetpc !== 1'b0) begin
      errors++;
      $display("FAIL error_sticky error=%b resetpc=%b exp 1 0", error, resetpc);
    end
  endtask

  task automatic test_count_bounds();
    clear_logs();
    in_valid = 1'b1;
    in_data = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b1;
    num_words = 8'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || resetpc !== 1'b1) begin
      errors++;
      $display("FAIL zero_words done=%b error=%b resetpc=%b exp 1 0 1",
               done, error, resetpc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wlog_addr.size() != 0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_words_nowrite writes=%0d in_ready=%b exp 0 0",
               wlog_addr.size(), in_ready);
    end
    start = 1'b1;
    num_words = 8'd129;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || resetpc !== 1'b0) begin
      errors++;
      $display("FAIL too_many error=%b done=%b resetpc=%b exp 1 0 0",
               error, done, resetpc);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    int when;
    for (int i = 0; i < 5; i++) img[i] = 32'hA000_0000 + 32'(i * 17);
    clear_logs();
    run_load(5, 1'b0, 2);
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, we0, resetpc, done, error} !== 5'b0 ||
        wr_addr0 !== 9'd0 || wr_din0 !== 32'd0 || rd_addr !== 9'd0) begin
      errors++;
      $display("FAIL async_abort flags=%b wr_addr0=%0d wr_din0=%h rd_addr=%0d exp 0",
               {in_ready, we0, resetpc, done, error}, wr_addr0, wr_din0, rd_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) img[i] = 32'h0B00_0000 + 32'(i * 3);
    clear_logs();
    run_load(5, 1'b0, 0);
    wait_end(40, when);
    check_image("reload", 5);
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL reload_done done=%b error=%b exp 1 0", done, error);
    end
  endtask

  task automatic test_back_to_back();
    int when;
    for (int i = 0; i < 128; i++)
      img[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    clear_logs();
    run_load(128, 1'b0, 0);
    checks++;
    if (rpc_after_start !== 1'b0) begin
      errors++;
      $display("FAIL restart_resetpc got=%b exp 0", rpc_after_start);
    end
    checks++;
    if (wlog_rpc.size() == 0 || wlog_rpc[0] !== 1'b0) begin
      errors++;
      $display("FAIL restart_first_write resetpc must be 0 at first we0");
    end
    wait_end(300, when);
    check_image("full", 128);
    checks++;
    if (wlog_addr.size() == 0 || wlog_addr[wlog_addr.size() - 1] !== 9'd508) begin
      errors++;
      $display("FAIL full_last_addr got=%0d exp=508",
               (wlog_addr.size() > 0) ? int'(wlog_addr[wlog_addr.size() - 1]) : -1);
    end
    checks++;
    if (done !== 1'b1 || resetpc !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL full_done done=%b resetpc=%b error=%b exp 1 1 0",
               done, resetpc, error);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    start = 1'b0;
    num_words = 8'd0;
    in_valid = 1'b0;
    in_data = 32'd0;
    flip_en = 1'b0;
    rpc_after_start = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 32'd0;
      img[i] = 32'd0;
    end
    test_reset();
    test_basic();
    test_toggle_valid();
    test_verify_error();
    test_count_bounds();
    test_reset_mid_load();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
